// File: rtl/axilite_master_traffic_gen.sv
// axilite_master_traffic_gen: AXI-lite master issuing NUM_TXNS strided writes and/or reads (MODE 0/1/2) with an optional read-back compare, counting errors into err_count; start/busy/done control, m_axi_* AW/W/B/AR/R channels
module axilite_master_traffic_gen #(
    parameter int          AXILITE_ADDR_WIDTH = 48,
    parameter int          AXILITE_DATA_WIDTH = 64,
    parameter int          NUM_TXNS           = 16,
    parameter logic [63:0] ADDR_BASE          = 64'h2000_0000,
    parameter logic [63:0] ADDR_STRIDE        = 64'd8,
    parameter logic [63:0] DATA_SEED          = 64'd0,
    parameter int          GAP_CYCLES         = 0,
    parameter int          MODE               = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   err_count,
    output logic [AXILITE_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXILITE_DATA_WIDTH-1:0] m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [AXILITE_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [AXILITE_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);
    localparam int AW = AXILITE_ADDR_WIDTH;
    localparam int DW = AXILITE_DATA_WIDTH;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, GAP, FINISH} state_t;
    state_t state, state_nxt;
    logic [15:0] idx;
    logic [7:0]  gap_cnt;
    logic        aw_done, w_done, rd_pass;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, last, txn_end, pass_end, bad;
    state_t      req_nxt;
    assign m_axi_awaddr  = AW'(ADDR_BASE) + AW'(idx) * AW'(ADDR_STRIDE);
    assign m_axi_araddr  = m_axi_awaddr;
    assign m_axi_wdata   = DW'(DATA_SEED) + DW'(idx);
    assign m_axi_awvalid = state == WR_REQ && !aw_done;
    assign m_axi_wvalid  = state == WR_REQ && !w_done;
    assign m_axi_bready  = state == WR_RESP;
    assign m_axi_arvalid = state == RD_REQ;
    assign m_axi_rready  = state == RD_RESP;
    assign busy          = state != IDLE && state != FINISH;
    assign done          = state == FINISH;
    assign aw_hs    = m_axi_awvalid & m_axi_awready;
    assign w_hs     = m_axi_wvalid & m_axi_wready;
    assign b_hs     = m_axi_bvalid & m_axi_bready;
    assign ar_hs    = m_axi_arvalid & m_axi_arready;
    assign r_hs     = m_axi_rvalid & m_axi_rready;
    assign last     = idx == 16'(NUM_TXNS - 1);
    assign txn_end  = b_hs | r_hs;
    assign pass_end = txn_end & last & (MODE != 2 || rd_pass);
    // After the final write of a MODE 2 run the next request is the first read.
    assign req_nxt  = (rd_pass || (last && MODE == 2)) ? RD_REQ : WR_REQ;
    // Read compare reuses wdata, which tracks DATA_SEED + idx for the current transaction.
    assign bad      = b_hs ? m_axi_bresp != 2'b00
                           : (m_axi_rresp != 2'b00 || (MODE == 2 && m_axi_rdata != m_axi_wdata));
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? (MODE == 1 ? RD_REQ : WR_REQ) : IDLE;
            WR_REQ:  state_nxt = ((aw_done | aw_hs) && (w_done | w_hs)) ? WR_RESP : WR_REQ;
            WR_RESP, RD_RESP:
                if (txn_end) state_nxt = pass_end ? FINISH : (GAP_CYCLES > 0 ? GAP : req_nxt);
            RD_REQ:  state_nxt = ar_hs ? RD_RESP : RD_REQ;
            GAP:     state_nxt = gap_cnt == 8'd0 ? (rd_pass ? RD_REQ : WR_REQ) : GAP;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            err_count <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rd_pass   <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            aw_done <= state_nxt == WR_REQ && (aw_done || aw_hs);
            w_done  <= state_nxt == WR_REQ && (w_done || w_hs);
            gap_cnt <= state == GAP ? gap_cnt - 8'd1 : 8'(GAP_CYCLES - 1);
            if (txn_end && !pass_end) idx <= last ? '0 : idx + 16'd1;
            if (txn_end && last && MODE == 2) rd_pass <= 1'b1;
            if (txn_end && bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (state == IDLE && start) begin
                idx       <= '0;
                err_count <= '0;
                rd_pass   <= MODE == 1;
            end
        end
    end
endmodule

// File: tb/tb_axilite_master_traffic_gen.sv
// tb_axilite_master_traffic_gen: directed checks of the AXI-lite traffic generator against a small slave model
module tb_axilite_master_traffic_gen;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, x_start = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    logic busy, done, awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [15:0] err_count;
    logic [47:0] awaddr, araddr, last_ar, pend_aw;
    logic [63:0] wdata, rdata, pend_w;
    logic [1:0]  bresp, rresp;
    logic [63:0] mem [16];
    int aw_delay = 0, aw_wait = 0, bad_b = -1, bad_r = -1, wr_cnt = 0, rd_cnt = 0;
    axilite_master_traffic_gen #(.NUM_TXNS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err_count(err_count),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );
    assign awready = awvalid && (aw_wait >= aw_delay - 1);
    assign wready  = 1'b1;
    assign arready = 1'b1;
    assign bvalid  = 1'b1;
    assign rvalid  = 1'b1;
    assign rresp   = 2'b00;
    assign bresp   = (wr_cnt == bad_b) ? 2'd2 : 2'd0;
    assign rdata   = (rd_cnt == bad_r) ? 64'hDEAD : mem[last_ar[6:3]];
    always @(posedge clk) begin
        aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
        if (awvalid && awready) pend_aw <= awaddr;
        if (wvalid && wready) pend_w <= wdata;
        if (bvalid && bready) begin
            mem[pend_aw[6:3]] <= pend_w;
            wr_cnt <= wr_cnt + 1;
        end
        if (arvalid && arready) last_ar <= araddr;
        if (rvalid && rready) rd_cnt <= rd_cnt + 1;
        if (start && !busy) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end
    end
    logic [63:0] aw_q[$], w_q[$], ar_q[$];
    int done_cnt = 0, b_cnt = 0, aw_hi = 0, w_hi = 0, aw_unstable = 0;
    logic aw_pend = 1'b0;
    logic [47:0] aw_hold;
    always @(negedge clk) begin
        if (awvalid && awready) aw_q.push_back(64'(awaddr));
        if (wvalid && wready) w_q.push_back(wdata);
        if (arvalid && arready) ar_q.push_back(64'(araddr));
        if (done) done_cnt++;
        if (bvalid && bready) b_cnt++;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (awvalid && aw_pend && awaddr != aw_hold) aw_unstable++;
        aw_pend = awvalid && !awready;
        aw_hold = awaddr;
    end
    logic x_busy, x_done, x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready;
    logic [15:0] x_err, x_wdata, x_rdata;
    logic [7:0]  x_awaddr, x_araddr, x_last_ar;
    logic [15:0] xmem [256];
    axilite_master_traffic_gen #(
        .AXILITE_ADDR_WIDTH(8), .AXILITE_DATA_WIDTH(16), .NUM_TXNS(3),
        .ADDR_BASE(64'hF8), .ADDR_STRIDE(64'd8), .GAP_CYCLES(5), .MODE(2)
    ) u_gap (
        .clk(clk), .rst(rst), .start(x_start), .busy(x_busy), .done(x_done), .err_count(x_err),
        .m_axi_awaddr(x_awaddr), .m_axi_awvalid(x_awvalid), .m_axi_awready(1'b1),
        .m_axi_wdata(x_wdata), .m_axi_wvalid(x_wvalid), .m_axi_wready(1'b1),
        .m_axi_bresp(2'b00), .m_axi_bvalid(1'b1), .m_axi_bready(x_bready),
        .m_axi_araddr(x_araddr), .m_axi_arvalid(x_arvalid), .m_axi_arready(1'b1),
        .m_axi_rdata(x_rdata), .m_axi_rresp(2'b00), .m_axi_rvalid(1'b1), .m_axi_rready(x_rready)
    );
    assign x_rdata = xmem[x_last_ar];
    always @(posedge clk) begin
        if (x_awvalid) xmem[x_awaddr] <= x_wdata;
        if (x_arvalid) x_last_ar <= x_araddr;
    end
    logic [63:0] x_aw_q[$], x_ar_q[$];
    int gaps[$];
    int gap_run = 0;
    logic gap_arm = 1'b0;
    always @(negedge clk) begin
        if (x_awvalid) x_aw_q.push_back(64'(x_awaddr));
        if (x_arvalid) x_ar_q.push_back(64'(x_araddr));
        if (x_bready || x_rready) begin
            gap_run = 0;
            gap_arm = 1'b1;
        end else if (gap_arm) begin
            if (x_awvalid || x_arvalid) begin
                gaps.push_back(gap_run);
                gap_arm = 1'b0;
            end else gap_run++;
        end
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic clear_logs();
        aw_q.delete();
        w_q.delete();
        ar_q.delete();
        done_cnt = 0;
        b_cnt = 0;
        aw_hi = 0;
        w_hi = 0;
        aw_unstable = 0;
    endtask
    task automatic run_a(input string tag, input int poke, output logic [15:0] err_at_done);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_up"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 500) begin
            start = (n == poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_timeout"}, 64'(n < 500), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        err_at_done = err_count;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask
    initial begin
        logic [15:0] e;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_awaddr", 64'(awaddr), 64'h2000_0000);
        check("rst_araddr", 64'(araddr), 64'h2000_0000);
        check("rst_wdata", wdata, 64'd0);
        check("rst_x_awaddr", 64'(x_awaddr), 64'hF8);
        clear_logs();
        run_a("basic", 3, e);
        check("basic_err", 64'(e), 64'd0);
        check("basic_aw_n", 64'(aw_q.size()), 64'd4);
        check("basic_ar_n", 64'(ar_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_aw%0d", i), aw_q[i], 64'h2000_0000 + 64'(8 * i));
            check($sformatf("basic_w%0d", i), w_q[i], 64'(i));
            check($sformatf("basic_ar%0d", i), ar_q[i], 64'h2000_0000 + 64'(8 * i));
        end
        clear_logs();
        aw_delay = 3;
        run_a("awdly", -1, e);
        check("awdly_err", 64'(e), 64'd0);
        check("awdly_aw_hi", 64'(aw_hi), 64'd12);
        check("awdly_w_hi", 64'(w_hi), 64'd4);
        check("awdly_stable", 64'(aw_unstable), 64'd0);
        check("awdly_b_beats", 64'(b_cnt), 64'd4);
        aw_delay = 0;
        clear_logs();
        bad_b = 1;
        bad_r = 2;
        run_a("errs", -1, e);
        check("errs_err", 64'(e), 64'd2);
        @(negedge clk);
        check("errs_hold", 64'(err_count), 64'd2);
        bad_b = -1;
        bad_r = -1;
        clear_logs();
        aw_delay = 1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_aw_wait", 64'(awvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        aw_delay = 0;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        clear_logs();
        run_a("rerun", -1, e);
        check("rerun_aw0", aw_q.size() > 0 ? aw_q[0] : 64'hX, 64'h2000_0000);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("rst_prio_idle", 64'(busy), 64'd0);
        x_start = 1'b1;
        @(negedge clk);
        x_start = 1'b0;
        n = 0;
        while (!x_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("gap_timeout", 64'(n < 500), 64'd1);
        check("gap_err", 64'(x_err), 64'd0);
        check("gap_aw_n", 64'(x_aw_q.size()), 64'd3);
        check("gap_aw0", x_aw_q[0], 64'hF8);
        check("gap_aw1", x_aw_q[1], 64'h00);
        check("gap_aw2", x_aw_q[2], 64'h08);
        check("gap_ar1", x_ar_q.size() > 1 ? x_ar_q[1] : 64'hX, 64'h00);
        check("gap_n", 64'(gaps.size()), 64'd5);
        foreach (gaps[i]) check($sformatf("gap%0d", i), 64'(gaps[i]), 64'd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axilite_master_traffic_gen.md
AXILITE_MASTER_TRAFFIC_GEN -- requirements
Module: axilite_master_traffic_gen

Interface
REQ-001: Parameter AXILITE_ADDR_WIDTH, default 48, SHALL set the width of every AXI-lite address.
REQ-002: Parameter AXILITE_DATA_WIDTH, default 64, SHALL set the width of every AXI-lite data bus.
REQ-003: Parameter NUM_TXNS, default 16, SHALL set the transactions per run; legal range 1..65535.
REQ-004: Parameter ADDR_BASE, default 'h20000000, SHALL set the address of transaction 0.
REQ-005: Parameter ADDR_STRIDE, default 8, SHALL set the address increment per transaction.
REQ-006: Parameter DATA_SEED, default 0, SHALL set the data of transaction 0.
REQ-007: Parameter GAP_CYCLES, default 0, SHALL set the idle cycles between transactions; legal range 0..255.
REQ-008: Parameter MODE, default 2, SHALL select 0 = write only, 1 = read only, 2 = write pass then read-back compare pass.
REQ-009: Ports SHALL be:
 clk  in  1  clock; all logic on rising edge
 rst  in  1  synchronous reset, active-high
 start  in  1  1-cycle pulse, begins a run; ignored unless idle
 busy  out  1  run in progress
 done  out  1  1-cycle pulse at end of run
 err_count  out  16  saturating count of response/compare errors in the current run
 m_axi_awaddr/awvalid/awready  out/out/in  ADDR/1/1  write address channel
 m_axi_wdata/wvalid/wready  out/out/in  DATA/1/1  write data channel
 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
 m_axi_araddr/arvalid/arready  out/out/in  ADDR/1/1  read address channel
 m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA/2/1/1  read data channel

Function
REQ-010: States SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, GAP, FINISH.
REQ-011: IDLE + start SHALL go to WR_REQ (MODE 0/2) or RD_REQ (MODE 1), clear index and err_count, and set busy the next cycle.
REQ-012: Transaction i SHALL use address ADDR_BASE + i*ADDR_STRIDE and data DATA_SEED + i, each truncated modulo 2^width (wrap-around silent).
REQ-013: In WR_REQ awvalid and wvalid SHALL rise in the same cycle; each SHALL stay high with stable payload until its own ready is sampled high, independently of the other.
REQ-014: WR_REQ SHALL advance to WR_RESP in the cycle after the later of the two handshakes (same cycle if both occur together).
REQ-015: bready SHALL be high only in WR_RESP; the bvalid&bready beat SHALL end the transaction; bresp != 0 SHALL increment err_count.
REQ-016: In RD_REQ arvalid SHALL be held with stable araddr until arready; then RD_RESP.
REQ-017: rready SHALL be high only in RD_RESP; the rvalid&rready beat SHALL end the transaction; rresp != 0, or in MODE 2 rdata != DATA_SEED + i, SHALL increment err_count once per beat (both faults = one increment).
REQ-018: err_count SHALL saturate at 16'hFFFF.
REQ-019: Only one transaction SHALL be outstanding; no new valid until the prior response is accepted.
REQ-020: After a transaction ends, if GAP_CYCLES > 0 the FSM SHALL spend exactly GAP_CYCLES cycles in GAP with all valids low; else it SHALL go directly to the next request state.
REQ-021: After transaction NUM_TXNS-1 of a pass: MODE 2 write pass SHALL reset index to 0 and continue with the read pass; otherwise FINISH.
REQ-022: FINISH SHALL pulse done for one cycle, drop busy the same cycle, and return to IDLE; err_count SHALL hold until next start.
REQ-023: start while busy SHALL have no effect.
REQ-024: Responses arriving outside their response state SHALL be ignored (ready low).

Reset
REQ-025: rst SHALL force IDLE and drive awvalid, wvalid, bready, arvalid, rready, busy, done low, err_count 0, index 0, awaddr/araddr ADDR_BASE, wdata DATA_SEED.
REQ-026: rst mid-transaction SHALL drop all valids the next cycle without completing handshakes; no done pulse.
REQ-027: rst SHALL take priority over start in the same cycle.

Verification
REQ-028: MODE 2, NUM_TXNS 4, zero-latency slave, GAP 0 -> writes 0x20000000..0x20000018 data 0..3, reads same, done once, err_count 0.
REQ-029: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 beat, awvalid holds 3 cycles with stable awaddr, single bready beat.
REQ-030: Slave returns bresp=2 on txn 1 and rdata 0xDEAD on read 2 -> err_count 2 at done.
REQ-031: GAP_CYCLES 5 -> exactly 5 cycles between response beat and next valid.
REQ-032: rst asserted while awvalid high awaiting awready -> valids low next cycle, busy 0, no done; next start reissues 0x20000000.
REQ-033: ADDR_WIDTH 8, ADDR_BASE 'hF8, STRIDE 8, NUM_TXNS 3 -> addresses F8, 00, 08.
